// File: rtl/csa_sum_accumulator_pkg.sv
// Shared types and default constants for the carry-select adder sum accumulator.
package csa_sum_accumulator_pkg;

  localparam int unsigned SUM_W_DEF = 29;
  localparam int unsigned ACC_W_DEF = 37;
  localparam int unsigned LAT_DEF   = 3;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/csa_sum_accumulator_valid_delay_line.sv
// LAT-deep valid shift register; aligns an operand-side valid with a pipelined adder's sum.
module valid_delay_line
  import csa_sum_accumulator_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic vld,
  output logic vld_al
);

  logic [LAT-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= vld;
      for (int unsigned i = 1; i < LAT; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign vld_al = sr[LAT-1];

endmodule

// File: rtl/csa_sum_accumulator.sv
// Accumulates a block of aligned adder sums and presents the total via valid/ready.
// Define CSA_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module csa_sum_accumulator
  import csa_sum_accumulator_pkg::*;
#(
  parameter int unsigned SUM_W = SUM_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned LAT   = LAT_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] block_len,
  input  logic             op_valid,
  input  logic [SUM_W-1:0] sum_in,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             busy,
  output logic             overflow,
  output logic             dropped
);

  state_t           state, state_d;
  logic [ACC_W-1:0] acc, acc_d, acc_out_d, acc_add;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] count, count_d, count_inc, len_q, len_d;
  logic             acc_valid_d, overflow_d, dropped_d, busy_d;
  logic             vld_al, carry;

  valid_delay_line #(.LAT(LAT)) u_vdl (
    .clk    (clk),
    .rst    (rst),
    .vld    (op_valid),
    .vld_al (vld_al)
  );

  assign sum_ext   = {1'b0, acc} + (ACC_W+1)'(sum_in);
  assign carry     = sum_ext[ACC_W];
  assign count_inc = count + 1'b1;

`ifdef CSA_ACC_SATURATE_EN
  // overflow is cleared on every accepted start, so it marks saturation within this block
  assign acc_add = (carry || overflow) ? '1 : sum_ext[ACC_W-1:0];
`else
  assign acc_add = sum_ext[ACC_W-1:0];
`endif

  always_comb begin
    state_d     = state;
    acc_d       = acc;
    count_d     = count;
    len_d       = len_q;
    acc_out_d   = acc_out;
    acc_valid_d = acc_valid;
    overflow_d  = overflow;
    dropped_d   = 1'b0;
    case (state)
      IDLE: begin
        dropped_d = vld_al;
        if (start) begin
          len_d      = block_len;
          acc_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          if (block_len == '0) begin
            acc_out_d   = '0;
            acc_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (vld_al) begin
          acc_d      = acc_add;
          count_d    = count_inc;
          overflow_d = overflow | carry;
          if (count_inc == len_q) begin
            acc_out_d   = acc_add;
            acc_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        dropped_d = vld_al;
        if (acc_valid && acc_ready) begin
          acc_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      len_q     <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      count     <= count_d;
      len_q     <= len_d;
      acc_out   <= acc_out_d;
      acc_valid <= acc_valid_d;
      busy      <= busy_d;
      overflow  <= overflow_d;
      dropped   <= dropped_d;
    end
  end

endmodule
